// File: rtl/gate_check_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gate_check_pkg
//  Description : Shared definitions for the gate stimulus checker: FSM state
//                encoding, the fixed {a,b} stimulus table and the bit
//                positions of each gate in the expected/mismatch vectors.
//  Revision    : 1.0  initial release
// ============================================================================
package gate_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Entry i is the {a,b} pair driven for vector index i: 00, 10, 01, 11.
    localparam logic [3:0][1:0] VEC_TABLE = {2'b11, 2'b01, 2'b10, 2'b00};

    // Bit positions inside the 7-bit expected / mismatch vectors.
    localparam int MB_AND  = 6;
    localparam int MB_OR   = 5;
    localparam int MB_NOR  = 4;
    localparam int MB_NOT  = 3;
    localparam int MB_NAND = 2;
    localparam int MB_XNOR = 1;
    localparam int MB_XOR  = 0;

    localparam int MASK_W  = 7;

endpackage : gate_check_pkg
`default_nettype wire

// File: rtl/gate_golden_model.sv
`default_nettype none
// ============================================================================
//  Module      : gate_golden_model
//  Description : Combinational reference for the two-input gate block. Maps
//                (a, b) to the expected seven gate outputs in mismatch-mask
//                bit order. The "not" output follows input a only.
//  Ports       : a_i, b_i     - stimulus values currently driven
//                expected_o   - [6]and [5]or [4]nor [3]not [2]nand
//                               [1]xnor [0]xor
//  Revision    : 1.0  initial release
// ============================================================================
module gate_golden_model
    import gate_check_pkg::*;
(
    input  logic              a_i,
    input  logic              b_i,
    output logic [MASK_W-1:0] expected_o
);

    always_comb begin
        expected_o          = '0;
        expected_o[MB_AND]  = a_i & b_i;
        expected_o[MB_OR]   = a_i | b_i;
        expected_o[MB_NOR]  = ~(a_i | b_i);
        expected_o[MB_NOT]  = ~a_i;
        expected_o[MB_NAND] = ~(a_i & b_i);
        expected_o[MB_XNOR] = ~(a_i ^ b_i);
        expected_o[MB_XOR]  = a_i ^ b_i;
    end

endmodule : gate_golden_model
`default_nettype wire

// File: rtl/gate_stim_checker.sv
`default_nettype none
// ============================================================================
//  Module      : gate_stim_checker
//  Description : Stimulus sequencer and checker for the two-input gate block.
//                Sweeps {a,b} through 00,10,01,11 NUM_PASSES times, lets each
//                vector settle for DWELL_CYCLES, then compares the seven gate
//                outputs with a golden model. Counts failing vectors
//                (saturating), captures the first failure, reports pass/fail.
//  Ports       : clk, rst          - clock, async active-high reset
//                start             - run request (honoured in IDLE/DONE only)
//                a_out, b_out      - stimulus to the gate block
//                and_in .. xor_in  - gate block outputs under test
//                busy, done, pass  - run status
//                err_count         - failing vectors, saturating
//                fail_seen         - at least one mismatch this run
//                first_fail_vec    - {a,b} of first failing vector
//                first_fail_mask   - mismatch bits of first failure
//  Revision    : 1.0  initial release
// ============================================================================
module gate_stim_checker
    import gate_check_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int NUM_PASSES   = 2,
    parameter int ERR_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic             and_in,
    input  logic             or_in,
    input  logic             nor_in,
    input  logic             not_in,
    input  logic             nand_in,
    input  logic             xnor_in,
    input  logic             xor_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_seen,
    output logic [1:0]       first_fail_vec,
    output logic [6:0]       first_fail_mask
);

    localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int PC_W = (NUM_PASSES   > 1) ? $clog2(NUM_PASSES)   : 1;

    localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL_CYCLES - 1);
    localparam logic [PC_W-1:0] LAST_PASS  = PC_W'(NUM_PASSES - 1);

    state_t              state_q,     state_d;
    logic [1:0]          vec_idx_q,   vec_idx_d;
    logic [PC_W-1:0]     pass_cnt_q,  pass_cnt_d;
    logic [DW_W-1:0]     dwell_q,     dwell_d;
    logic                a_q,         a_d;
    logic                b_q,         b_d;
    logic [ERR_W-1:0]    err_q,       err_d;
    logic                fail_seen_q, fail_seen_d;
    logic [1:0]          ffv_q,       ffv_d;
    logic [MASK_W-1:0]   ffm_q,       ffm_d;

    logic [MASK_W-1:0]   expected;
    logic [MASK_W-1:0]   observed;
    logic [MASK_W-1:0]   mismatch;
    logic [1:0]          next_idx;

    gate_golden_model u_golden (
        .a_i        (a_q),
        .b_i        (b_q),
        .expected_o (expected)
    );

    assign observed = {and_in, or_in, nor_in, not_in, nand_in, xnor_in, xor_in};
    assign mismatch = observed ^ expected;
    // Two-bit index wraps 3 -> 0 on its own.
    assign next_idx = vec_idx_q + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_idx_q   <= '0;
            pass_cnt_q  <= '0;
            dwell_q     <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            err_q       <= '0;
            fail_seen_q <= 1'b0;
            ffv_q       <= '0;
            ffm_q       <= '0;
        end else begin
            state_q     <= state_d;
            vec_idx_q   <= vec_idx_d;
            pass_cnt_q  <= pass_cnt_d;
            dwell_q     <= dwell_d;
            a_q         <= a_d;
            b_q         <= b_d;
            err_q       <= err_d;
            fail_seen_q <= fail_seen_d;
            ffv_q       <= ffv_d;
            ffm_q       <= ffm_d;
        end
    end

    // Stimulus is loaded on the edge that enters DRIVE, so a_out/b_out hold
    // the new vector for the whole DRIVE..CHECK window.
    always_comb begin
        state_d     = state_q;
        vec_idx_d   = vec_idx_q;
        pass_cnt_d  = pass_cnt_q;
        dwell_d     = dwell_q;
        a_d         = a_q;
        b_d         = b_q;
        err_d       = err_q;
        fail_seen_d = fail_seen_q;
        ffv_d       = ffv_q;
        ffm_d       = ffm_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_DRIVE;
                    vec_idx_d   = '0;
                    pass_cnt_d  = '0;
                    {a_d, b_d}  = VEC_TABLE[0];
                    err_d       = '0;
                    fail_seen_d = 1'b0;
                    ffv_d       = '0;
                    ffm_d       = '0;
                end
            end
            ST_DRIVE: begin
                dwell_d = DWELL_LOAD;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (dwell_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    dwell_d = dwell_q - 1'b1;
                end
            end
            ST_CHECK: begin
                if (mismatch != '0) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fail_seen_q) begin
                        fail_seen_d = 1'b1;
                        ffv_d       = {a_q, b_q};
                        ffm_d       = mismatch;
                    end
                end
                if ((vec_idx_q == 2'd3) && (pass_cnt_q == LAST_PASS)) begin
                    state_d = ST_DONE;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                end else begin
                    state_d    = ST_DRIVE;
                    vec_idx_d  = next_idx;
                    {a_d, b_d} = VEC_TABLE[next_idx];
                    if (vec_idx_q == 2'd3) begin
                        pass_cnt_d = pass_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign a_out           = a_q;
    assign b_out           = b_q;
    assign busy            = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) ||
                             (state_q == ST_CHECK);
    assign done            = (state_q == ST_DONE);
    assign pass            = (state_q == ST_DONE) && (err_q == '0);
    assign err_count       = err_q;
    assign fail_seen       = fail_seen_q;
    assign first_fail_vec  = ffv_q;
    assign first_fail_mask = ffm_q;

endmodule : gate_stim_checker
`default_nettype wire

// File: doc/gate_stim_checker.md
Name: gate_stim_checker

Overview:
Self-checking stimulus sequencer for the two-input gate block (a, b in; and/or/nor/not/nand/xnor/xor out).
- Drives a/b through the fixed vector sequence 00, 10, 01, 11.
- Waits a settle window, then samples the seven gate outputs and compares them against a golden model.
- Counts failing vectors, captures the first failure and reports pass/fail.
- Sits directly upstream of the gate block and consumes its outputs; replaces hand-written timed stimulus for on-board or simulation checks.

Parameters:
DWELL_CYCLES, 4, settle cycles between driving a vector and sampling; legal range >= 1
NUM_PASSES, 2, number of full sweeps through the 4-vector sequence; legal range >= 1
ERR_W, 8, width of the failing-vector counter

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  run request, sampled in IDLE or DONE only
a_out  out  1  stimulus a to gate block
b_out  out  1  stimulus b to gate block
and_in  in  1  gate block and output
or_in  in  1  gate block or output
nor_in  in  1  gate block nor output
not_in  in  1  gate block not output; golden value is ~a
nand_in  in  1  gate block nand output
xnor_in  in  1  gate block xnor output
xor_in  in  1  gate block xor output
busy  out  1  high in DRIVE/SETTLE/CHECK
done  out  1  high while in DONE
pass  out  1  valid when done: err_count == 0
err_count  out  ERR_W  failing vectors, saturating
fail_seen  out  1  at least one mismatch this run
first_fail_vec  out  2  {a,b} of first failing vector
first_fail_mask  out  7  mismatch bits of first failure: [6]and [5]or [4]nor [3]not [2]nand [1]xnor [0]xor

Behaviour:
- Reset (async assert, any state): state=IDLE. All outputs 0: a_out, b_out, busy, done, pass, err_count, fail_seen, first_fail_vec, first_fail_mask. Internal vec_idx, pass_cnt and dwell counter also 0.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE or DONE with start=1:
  - go to DRIVE; vec_idx=0, pass_cnt=0.
  - clear err_count, fail_seen, first_fail_*, done, pass.
- DRIVE (1 cycle): a_out/b_out take the table entry for vec_idx (0:00, 1:10, 2:01, 3:11); load dwell counter; go to SETTLE.
- SETTLE (exactly DWELL_CYCLES cycles): gate inputs are ignored; go to CHECK.
- CHECK (1 cycle): sample all seven inputs and XOR with golden(a_out, b_out) to form the mask.
  - If mask != 0: err_count += 1, saturating at 2^ERR_W-1.
  - If mask != 0 and fail_seen=0: capture first_fail_vec/mask and set fail_seen.
  - Then, if vec_idx==3 and pass_cnt==NUM_PASSES-1: go to DONE.
  - Else advance: vec_idx wraps 3->0 and increments pass_cnt; go to DRIVE.
- Errors are counted per vector, not per bit.
- DONE: done=1, pass=(err_count==0), a_out=b_out=0; results held until start or rst.
- start while busy is ignored and not queued.
- Latency: each vector occupies DWELL_CYCLES+2 cycles. done rises 4*NUM_PASSES*(DWELL_CYCLES+2) edges after the edge that sampled start (48 at defaults).
- a_out/b_out are stable from DRIVE through CHECK of the same vector.

Decomposition:
- Package gate_check_pkg holds:
  - FSM state encoding;
  - 4-entry vector table constant;
  - mismatch-mask bit-index constants.
- Sub-module gate_golden_model: purely combinational. Maps (a, b) to the expected 7-bit output vector in mask bit order, with not = ~a. It is instantiated once, fed from a_out/b_out.

Test Plan:
1. Correct gate model connected, defaults, start pulse -> done at edge 48; pass=1, err_count=0, fail_seen=0; a_out/b_out show sequence 00,10,01,11 twice.
2. xor_in stuck at 0 -> err_count=4 (vectors 10 and 01, both passes); first_fail_vec=2'b10, first_fail_mask=7'b0000001, pass=0.
3. start held high during run -> no restart, done still at edge 48. start pulse in DONE -> results cleared on next edge, new run completes identically.
4. rst asserted asynchronously at cycle 20 -> all outputs 0 immediately, state IDLE. A following start gives a clean run matching scenario 1.
5. ERR_W=2, all inputs inverted from golden -> err_count saturates at 3 (8 failing vectors); first_fail_vec=2'b00, first_fail_mask=7'b1111111.
6. Glitch xor_in wrong only during SETTLE cycles, correct in CHECK -> err_count=0, pass=1.
